// File: rtl/mult_pkg.sv
// ============================================================================
// mult_pkg : shared constants and state type for the sequential multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

package mult_pkg;

  localparam int         MUL_W    = 32;
  localparam logic [4:0] MUL_LAST = 5'd31;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } mult_state_t;

endpackage

`default_nettype wire

// File: rtl/and_gate_32bit.sv
// ============================================================================
// and_gate_32bit : 32-bit bitwise AND used to form multiplier partial products
// Rev 1.0
// ============================================================================
`default_nettype none

module and_gate_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  assign y = a & b;

endmodule

`default_nettype wire

// File: rtl/seq_multiplier_32bit.sv
// ============================================================================
// seq_multiplier_32bit : unsigned 32x32->64 shift-add multiplier, 34 cycles/op
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_multiplier_32bit
  import mult_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  mult_state_t r_state;
  mult_state_t w_state_next;

  logic [MUL_W-1:0] r_mcand;
  logic [MUL_W:0]   r_hi;
  logic [MUL_W-1:0] r_lo;
  logic [4:0]       r_count;
  logic             r_busy;
  logic             r_done;
  logic [63:0]      r_product;

  logic [MUL_W-1:0] w_pp;
  logic [MUL_W:0]   w_sum;
  logic [MUL_W:0]   w_hi_next;
  logic [MUL_W-1:0] w_lo_next;
  logic             w_accept;
  logic             w_last;

  and_gate_32bit u_and (
    .a (r_mcand),
    .b ({MUL_W{r_lo[0]}}),
    .y (w_pp)
  );

  // r_hi[32] is always zero after a step, so this equals {1'b0, hi[31:0]} + pp
  assign w_sum     = r_hi + {1'b0, w_pp};
  assign w_hi_next = {1'b0, w_sum[MUL_W:1]};
  assign w_lo_next = {w_sum[0], r_lo[MUL_W-1:1]};

  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_last    = (r_state == S_RUN) && (r_count == MUL_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == S_RUN);
      r_done  <= (w_state_next == S_DONE);

      if (w_accept) begin
        r_mcand <= A;
        r_lo    <= B;
        r_hi    <= '0;
        r_count <= '0;
      end else if (r_state == S_RUN) begin
        r_hi    <= w_hi_next;
        r_lo    <= w_lo_next;
        r_count <= r_count + 5'd1;
      end

      // Capture the result of the final iteration as the state enters DONE
      if (w_last) begin
        r_product <= {w_hi_next[MUL_W-1:0], w_lo_next};
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier_32bit.sv
// ============================================================================
// tb_seq_multiplier_32bit : directed self-checking bench for the multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seq_multiplier_32bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int tests;
  int fails;
  int cyc;

  seq_multiplier_32bit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sample i (1-based) is taken just after edge acc+i-1, i.e. cycle acc+i.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] prod, output int done_idx,
                          output int busy_cnt, output int overlap,
                          output int acc_cyc, output int done_cyc);
    prod = '0; done_idx = 0; busy_cnt = 0; overlap = 0; done_cyc = 0;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    start = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      if (busy) busy_cnt++;
      if (busy && done) overlap++;
      if (done) begin
        done_idx = i;
        done_cyc = cyc + 1;
        prod = product;
        break;
      end
      @(posedge clk); #1;
    end
    if (done_idx != 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, product} !== 66'h0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%0b done=%0b product=%h, required all 0", busy, done, product);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [63:0] p; int di, bc, ov, ac, dc;
    run_mult(32'd3, 32'd5, p, di, bc, ov, ac, dc);
    tests++;
    if (di !== 33) begin fails++; $display("FAIL basic_latency: done at cycle %0d, required 33", di); end
    tests++;
    if (p !== 64'd15) begin fails++; $display("FAIL basic_product: got %h, required %h", p, 64'd15); end
    tests++;
    if (bc !== 32) begin fails++; $display("FAIL basic_busy_len: busy %0d cycles, required 32", bc); end
    tests++;
    if (ov !== 0) begin fails++; $display("FAIL basic_busy_done_overlap: %0d cycles, required 0", ov); end
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse: done=%0b in cycle after DONE, required 0", done); end
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (product !== 64'd15) begin fails++; $display("FAIL basic_hold: product=%h in IDLE, required %h", product, 64'd15); end
  endtask

  task automatic test_max();
    logic [63:0] p; int di, bc, ov, ac, dc;
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, p, di, bc, ov, ac, dc);
    tests++;
    if (p !== 64'hFFFF_FFFE_0000_0001) begin fails++; $display("FAIL max_product: got %h, required %h", p, 64'hFFFF_FFFE_0000_0001); end
  endtask

  task automatic test_zero();
    logic [63:0] p; int di, bc, ov, ac, dc;
    run_mult(32'h0, 32'h1234_5678, p, di, bc, ov, ac, dc);
    tests++;
    if (p !== 64'h0 || di !== 33) begin fails++; $display("FAIL zero_mcand: got %h at cycle %0d, required 0 at 33", p, di); end
    run_mult(32'h8000_0000, 32'd2, p, di, bc, ov, ac, dc);
    tests++;
    if (p !== 64'h1_0000_0000) begin fails++; $display("FAIL high_bit: got %h, required %h", p, 64'h1_0000_0000); end
  endtask

  task automatic test_ignore_inputs();
    int di; int extra;
    @(negedge clk);
    A = 32'd1000; B = 32'd1000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    di = 0;
    for (int i = 1; i <= 60; i++) begin
      if (i == 10) begin A = 32'd7; B = 32'd7; start = 1'b1; end
      if (i == 11) start = 1'b0;
      if (done) begin di = i; break; end
      @(posedge clk); #1;
    end
    tests++;
    if (di !== 33 || product !== 64'd1_000_000) begin
      fails++;
      $display("FAIL ignore_product: got %h at cycle %0d, required %h at 33", product, di, 64'd1_000_000);
    end
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    tests++;
    if (extra !== 0) begin fails++; $display("FAIL ignore_no_second_done: %0d extra done pulses, required 0", extra); end
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] p; int di, bc, ov, ac, dc;
    @(negedge clk);
    A = 32'd1000; B = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL midreset_flags: busy=%0b done=%0b, required 0 0", busy, done); end
    tests++;
    if (product !== 64'h0) begin fails++; $display("FAIL midreset_product: got %h, required 0", product); end
    repeat (40) begin
      @(posedge clk); #1;
      if (done) begin
        tests++; fails++;
        $display("FAIL midreset_abort: done=1 after reset, required 0");
      end
    end
    run_mult(32'd6, 32'd7, p, di, bc, ov, ac, dc);
    tests++;
    if (p !== 64'd42 || di !== 33) begin fails++; $display("FAIL midreset_restart: got %h at cycle %0d, required %h at 33", p, di, 64'd42); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] p1, p2; int di1, di2, bc, ov, ac1, ac2, dc1, dc2;
    run_mult(32'd12, 32'd13, p1, di1, bc, ov, ac1, dc1);
    run_mult(32'hDEAD_BEEF, 32'd16, p2, di2, bc, ov, ac2, dc2);
    tests++;
    if (ac2 - ac1 !== 34) begin fails++; $display("FAIL b2b_accept: second start accepted %0d cycles later, required 34", ac2 - ac1); end
    tests++;
    if (dc2 - ac1 !== 67) begin fails++; $display("FAIL b2b_done: second done at N+%0d, required N+67", dc2 - ac1); end
    tests++;
    if (p1 !== 64'd156 || p2 !== 64'hD_EADB_EEF0) begin
      fails++;
      $display("FAIL b2b_products: got %h %h, required %h %h", p1, p2, 64'd156, 64'hD_EADB_EEF0);
    end
  endtask

  task automatic test_start_held();
    int n; int dcyc [2]; logic [63:0] dprod [2];
    n = 0;
    @(negedge clk);
    A = 32'd9; B = 32'd9; start = 1'b1;
    for (int i = 0; i < 120 && n < 2; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dcyc[n] = cyc; dprod[n] = product; n++;
        if (n == 1) begin A = 32'd10; B = 32'd11; end
        else start = 1'b0;
      end
    end
    start = 1'b0;
    tests++;
    if (n !== 2) begin
      fails++;
      $display("FAIL held_count: %0d done pulses, required 2", n);
    end else begin
      tests++;
      if (dcyc[1] - dcyc[0] !== 34) begin fails++; $display("FAIL held_period: %0d cycles, required 34", dcyc[1] - dcyc[0]); end
      tests++;
      if (dprod[0] !== 64'd81 || dprod[1] !== 64'd110) begin
        fails++;
        $display("FAIL held_products: got %h %h, required %h %h", dprod[0], dprod[1], 64'd81, 64'd110);
      end
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_ignore_inputs();
    test_reset_mid_run();
    test_back_to_back();
    test_start_held();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
